add_seq_ctrl: RTL and testbench

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

---
 rtl/add_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_add_seq_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/add_seq_ctrl.sv
// Byte-serial add/subtract sequencer driving a shared external 8-bit adder.
// One byte per slot (ISSUE + ADD_LAT WAIT cycles), least-significant byte first.
module add_seq_ctrl #(
  parameter int NBYTES  = 4,
  parameter int ADD_LAT = 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic                  Sub,
  input  logic [8*NBYTES-1:0]   Op_A,
  input  logic [8*NBYTES-1:0]   Op_B,
  output logic                  Ready,
  output logic                  Busy,
  output logic                  Done,
  output logic [8*NBYTES-1:0]   Result,
  output logic                  Carry_out,
  output logic                  Overflow,
  output logic [7:0]            Add_A,
  output logic [7:0]            Add_B,
  output logic                  Add_Cin,
  input  logic [7:0]            Add_S,
  input  logic                  Add_Cout
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NBYTES - 1);
  localparam logic [1:0]    WAIT_INIT = (ADD_LAT > 0) ? 2'(ADD_LAT - 1) : 2'd0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;      // B already inverted for subtraction
  logic            carry;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_next;
  logic [1:0]      wait_cnt;
  logic [W-1:0]    b_in;
  logic            slot_end;

  assign b_in     = Sub ? ~Op_B : Op_B;
  assign idx_next = idx + IW'(1);

  // The adder result is sampled on the edge that closes the current byte slot.
  assign slot_end = ((state == ISSUE) && (ADD_LAT == 0)) ||
                    ((state == WAIT) && (wait_cnt == 2'd0));

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      Ready     <= 1'b1;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Result    <= '0;
      Carry_out <= 1'b0;
      Overflow  <= 1'b0;
      Add_A     <= 8'd0;
      Add_B     <= 8'd0;
      Add_Cin   <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      wait_cnt  <= 2'd0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            a_reg   <= Op_A;
            b_reg   <= b_in;
            carry   <= Sub;
            idx     <= '0;
            Add_A   <= Op_A[7:0];
            Add_B   <= b_in[7:0];
            Add_Cin <= Sub;
            Ready   <= 1'b0;
            Busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (!slot_end) begin
            wait_cnt <= WAIT_INIT;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (!slot_end) wait_cnt <= wait_cnt - 2'd1;
        end
        default: state <= IDLE;
      endcase

      if (slot_end) begin
        Result[8*int'(idx) +: 8] <= Add_S;
        carry <= Add_Cout;
        if (idx == LAST_IDX) begin
          // Final byte: publish flags and park the adder inputs at zero.
          Carry_out <= Add_Cout;
          Overflow  <= (a_reg[W-1] == b_reg[W-1]) && (Add_S[7] != a_reg[W-1]);
          Done      <= 1'b1;
          Ready     <= 1'b1;
          Busy      <= 1'b0;
          Add_A     <= 8'd0;
          Add_B     <= 8'd0;
          Add_Cin   <= 1'b0;
          state     <= DONE;
        end else begin
          idx     <= idx_next;
          Add_A   <= a_reg[8*int'(idx_next) +: 8];
          Add_B   <= b_reg[8*int'(idx_next) +: 8];
          Add_Cin <= Add_Cout;
          state   <= ISSUE;
        end
      end
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Randomized plus directed bench for add_seq_ctrl with a one-cycle adder model
// and an arithmetic reference for sum, carry/no-borrow and signed overflow.
module tb_add_seq_ctrl;

  localparam int NB     = 4;
  localparam int LAT    = 1;
  localparam int OP_CYC = NB * (LAT + 1);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [7:0]  add_s;
  logic        add_cout;

  int n_cmp = 0;
  int n_bad = 0;
  int done_total = 0;

  add_seq_ctrl #(.NBYTES(NB), .ADD_LAT(LAT)) dut (
    .Clk(clk), .Rst_n(rst_n), .Start(start), .Sub(sub),
    .Op_A(op_a), .Op_B(op_b),
    .Ready(ready), .Busy(busy), .Done(done),
    .Result(result), .Carry_out(carry_out), .Overflow(overflow),
    .Add_A(add_a), .Add_B(add_b), .Add_Cin(add_cin),
    .Add_S(add_s), .Add_Cout(add_cout)
  );

  always #5 clk = ~clk;

  // External adder with one cycle of latency.
  always @(posedge clk) {add_cout, add_s} <= {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  always @(posedge clk) if (done) done_total++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {overflow, carry_out, result} from plain integer arithmetic.
  function automatic logic [33:0] ref_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint ua, ub, sa, sb, sr;
    logic [31:0] r;
    logic c, v;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      r  = a - b;
      c  = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = a + b;
      c  = (ua + ub) > 64'hFFFF_FFFF;
      sr = sa + sb;
    end
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {v, c, r};
  endfunction

  // Starts an operation from a post-edge time point and returns in the Done cycle.
  // inj > 0 pulses Start with junk operands after that many busy edges.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int inj);
    logic [33:0] exp;
    logic [31:0] bb;
    int n;
    bit got;
    exp   = ref_op(a, b, s);
    bb    = s ? ~b : b;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    sub   = s;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("ready_after_start", ready, 0);
    check("add_a_byte0", add_a, a[7:0]);
    check("add_b_byte0", add_b, bb[7:0]);
    check("add_cin_byte0", add_cin, s);
    got = 0;
    n   = 0;
    while (!got && n < 40) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (done) got = 1;
      else if (n == inj) begin
        start = 1'b1;
        op_a  = $urandom;
        op_b  = $urandom;
        sub   = 1'($urandom);
      end
    end
    check("done_seen", got, 1);
    check("latency", n, OP_CYC);
    check("result", result, exp[31:0]);
    check("carry_out", carry_out, exp[32]);
    check("overflow", overflow, exp[33]);
    check("ready_in_done", ready, 1);
    check("busy_in_done", busy, 0);
    check("add_a_idle", add_a, 0);
    $display("op %s a=%08h b=%08h -> r=%08h c=%0d v=%0d (%0d cycles)",
             s ? "sub" : "add", a, b, result, carry_out, overflow, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_cout"}, carry_out, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_adder_in"}, {add_a, add_b, add_cin}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    logic [31:0] keep;
    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed cases; the first Start lands on the first edge after reset release.
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 0);
    @(posedge clk); #1;

    // Start pulsed while busy must not disturb the operation.
    d0 = done_total;
    run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 3);
    keep = result;
    @(posedge clk); #1;
    check("single_done", done_total - d0, 1);
    check("done_dropped", done, 0);
    repeat (3) @(posedge clk);
    #1;
    check("result_holds", result, keep);

    // Randomized operations, some issued in the Done cycle with no gap.
    for (int i = 0; i < 40; i++) begin
      run_op($urandom, $urandom, 1'($urandom), 0);
      if ($urandom_range(2) != 0) begin
        keep = result;
        repeat ($urandom_range(3, 1)) @(posedge clk);
        #1;
        check("rand_hold", result, keep);
        check("rand_idle_done", done, 0);
      end
    end

    // Abort mid-operation with reset, then restart immediately.
    @(posedge clk); #1;
    d0    = done_total;
    start = 1'b1;
    op_a  = 32'hA5A5_A5A5;
    op_b  = 32'h5A5A_5A5A;
    sub   = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (6) @(posedge clk);
    #1;
    check("no_done_aborted", done_total - d0, 0);
    rst_n = 1'b1;
    run_op(32'h0000_0010, 32'h0000_0020, 1'b0, 0);
    @(posedge clk); #1;
    check("done_after_abort", done_total - d0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
